// File: rtl/simplerisc_pkg.sv
// SimpleRisc decode definitions: op5 codes, control-bus bit indices and the
// opcode -> control-bus decode function shared by the decode stage.
package simplerisc_pkg;

    localparam int OPCODE_W = 6;
    localparam int CTRL_W   = 25;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [4:0] OP_CMP = 5'd5;
    localparam logic [4:0] OP_AND = 5'd6;
    localparam logic [4:0] OP_OR  = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8;
    localparam logic [4:0] OP_MOV = 5'd9;
    localparam logic [4:0] OP_LSL = 5'd10;
    localparam logic [4:0] OP_LSR = 5'd11;
    localparam logic [4:0] OP_ASR = 5'd12;
    localparam logic [4:0] OP_NOP = 5'd13;
    localparam logic [4:0] OP_LD  = 5'd14;
    localparam logic [4:0] OP_ST  = 5'd15;
    localparam logic [4:0] OP_BEQ = 5'd16;
    localparam logic [4:0] OP_BGT = 5'd17;
    localparam logic [4:0] OP_B   = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET = 5'd20;
    localparam logic [4:0] OP_ILL_LO = 5'd21;
    localparam logic [4:0] OP_ILL_HI = 5'd30;
    localparam logic [4:0] OP_HLT = 5'd31;

    localparam int CTRL_MUL     = 2;
    localparam int CTRL_DIV     = 3;
    localparam int CTRL_MOD     = 4;
    localparam int CTRL_IMM     = 20;
    localparam int CTRL_WB      = 21;
    localparam int CTRL_NOP     = 22;
    localparam int CTRL_HLT     = 23;
    localparam int CTRL_ILLEGAL = 24;

    function automatic logic [CTRL_W-1:0] decode_op(input logic [OPCODE_W-1:0] opcode);
        logic [4:0]        op5;
        logic [CTRL_W-1:0] c;
        op5         = opcode[5:1];
        c           = '0;
        c[CTRL_IMM] = opcode[0];
        // nop has no one-hot bit, so ld..ret sit one position below their op5
        if (op5 <= OP_ASR)
            c[op5] = 1'b1;
        else if (op5 >= OP_LD && op5 <= OP_RET)
            c[op5 - 5'd1] = 1'b1;
        c[CTRL_WB]      = !(op5 == OP_CMP || op5 == OP_NOP || op5 == OP_ST || op5[4]);
        c[CTRL_NOP]     = (op5 == OP_NOP);
        c[CTRL_HLT]     = (op5 == OP_HLT);
        c[CTRL_ILLEGAL] = (op5 >= OP_ILL_LO && op5 <= OP_ILL_HI);
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational decode of the instruction's top opcode bits into the
// SimpleRisc control bus.
module ctrl_decode_comb
    import simplerisc_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [CTRL_W-1:0]  ctrl
);

    assign ctrl = decode_op(instr[INSTR_W-1 -: OPCODE_W]);

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered SimpleRisc decode stage between IF and OF: valid/ready handshake,
// multi-cycle mul/div/mod countdown, flush and sticky halt.
module ctrl_decode_stage
    import simplerisc_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int MUL_CYC = 3,
    parameter int DIV_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               busy,
    output logic               halted
);

    localparam int CYC_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_load;
    logic              hlt_pend;
    logic              accept;
    logic              transfer;

    ctrl_decode_comb #(.INSTR_W(INSTR_W)) u_decode (
        .instr (in_instr),
        .ctrl  (dec_ctrl)
    );

    always_comb begin
        cnt_load = '0;
        if (dec_ctrl[CTRL_MUL])
            cnt_load = CNT_W'(MUL_CYC - 1);
        else if (dec_ctrl[CTRL_DIV] || dec_ctrl[CTRL_MOD])
            cnt_load = CNT_W'(DIV_CYC - 1);
    end

    assign in_ready = !halted && !hlt_pend && !flush && (cnt == '0) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign busy     = (cnt != '0);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_instr <= '0;
            out_pc    <= '0;
            cnt       <= '0;
            hlt_pend  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            // a hlt leaving the stage counts even if flush arrives the same cycle
            if (transfer && out_ctrl[CTRL_HLT])
                halted <= 1'b1;

            if (flush) begin
                out_valid <= 1'b0;
                cnt       <= '0;
                hlt_pend  <= 1'b0;
            end else if (accept) begin
                out_instr <= in_instr;
                out_pc    <= in_pc;
                out_ctrl  <= dec_ctrl;
                cnt       <= cnt_load;
                out_valid <= (cnt_load == '0);
                hlt_pend  <= dec_ctrl[CTRL_HLT];
            end else begin
                if (transfer) begin
                    out_valid <= 1'b0;
                    if (out_ctrl[CTRL_HLT])
                        hlt_pend <= 1'b0;
                end
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed testbench for ctrl_decode_stage: decode values, handshake, multi-cycle
// stall, backpressure, flush, halt and asynchronous reset.
module tb_ctrl_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_ctrl;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;
    logic        halted;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_decode_stage #(.INSTR_W(32), .PC_W(32), .MUL_CYC(3), .DIV_CYC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .busy      (busy),
        .halted    (halted)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [31:0] pc);
        return {op, pc[25:0] ^ 26'h0155aa3};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = mk(op, pc);
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        checks++; if (out_ctrl !== 25'h0) begin errors++; $display("FAIL reset_ctrl got=%0h exp=0", out_ctrl); end
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL reset_payload got pc=%0h instr=%0h exp=0", out_pc, out_instr); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%0b halted=%0b exp=0", busy, halted); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        logic [5:0]  ops [3]  = '{6'h00, 6'h03, 6'h1E};
        logic [24:0] exp [3]  = '{25'h200001, 25'h300002, 25'h004000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(ops[i], 32'h100 + 32'(4 * i));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, out_valid); end
            checks++; if (out_ctrl !== exp[i]) begin errors++; $display("FAIL stream_ctrl[%0d] got=%0h exp=%0h", i, out_ctrl, exp[i]); end
            checks++; if (out_pc !== 32'h100 + 32'(4 * i) || out_instr !== mk(ops[i], 32'h100 + 32'(4 * i))) begin
                errors++; $display("FAIL stream_payload[%0d] got pc=%0h instr=%0h", i, out_pc, out_instr); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_decode_table();
        logic [5:0]  ops [8] = '{6'h1C, 6'h0A, 6'h20, 6'h1A, 6'h28, 6'h13, 6'h18, 6'h27};
        logic [24:0] exp [8] = '{25'h202000, 25'h000020, 25'h008000, 25'h400000,
                                 25'h080000, 25'h300200, 25'h201000, 25'h140000};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            present(ops[i], 32'h180 + 32'(4 * i));
            tick();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== exp[i]) begin
                errors++; $display("FAIL decode_op%0h got valid=%0b ctrl=%0h exp ctrl=%0h", ops[i], out_valid, out_ctrl, exp[i]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        present(6'h04, 32'h200);
        tick();
        present(6'h00, 32'h204);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL mul_stall[%0d] got busy=%0b valid=%0b in_ready=%0b exp 1/0/0", i, busy, out_valid, in_ready); end
            tick();
        end
        #1;
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 25'h200004 || out_pc !== 32'h200) begin
            errors++; $display("FAIL mul_out got valid=%0b ctrl=%0h pc=%0h exp 1/200004/200", out_valid, out_ctrl, out_pc); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mul_release got busy=%0b in_ready=%0b exp 0/1", busy, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 25'h200001 || out_pc !== 32'h204) begin
            errors++; $display("FAIL mul_next got valid=%0b ctrl=%0h pc=%0h exp 1/200001/204", out_valid, out_ctrl, out_pc); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        present(6'h0C, 32'h300);
        tick();
        out_ready = 1'b0;
        present(6'h0E, 32'h304);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== 25'h200040 || out_pc !== 32'h300) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%0b ctrl=%0h pc=%0h exp 1/200040/300", i, out_valid, out_ctrl, out_pc); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 25'h200080 || out_pc !== 32'h304) begin
            errors++; $display("FAIL bp_next got valid=%0b ctrl=%0h pc=%0h exp 1/200080/304", out_valid, out_ctrl, out_pc); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        present(6'h06, 32'h400);
        tick();
        present(6'h14, 32'h404);
        for (int i = 0; i < 4; i++) begin
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_count[%0d] got busy=%0b valid=%0b exp 1/0", i, busy, out_valid); end
            if (i < 3) tick();
        end
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_kill got busy=%0b valid=%0b exp 0/0", busy, out_valid); end
        flush = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_reaccept got=%0b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 25'h200400 || out_pc !== 32'h404) begin
            errors++; $display("FAIL flush_next got valid=%0b ctrl=%0h pc=%0h exp 1/200400/404", out_valid, out_ctrl, out_pc); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        out_ready = 1'b0;
        present(6'h3E, 32'h500);
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 25'h800000 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_out got valid=%0b ctrl=%0h halted=%0b exp 1/800000/0", out_valid, out_ctrl, halted); end
        present(6'h00, 32'h504);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_pend_ready got=%0b exp=0", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL halt_set got halted=%0b valid=%0b exp 1/0", halted, out_valid); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready[%0d] got=%0b exp=0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin
                errors++; $display("FAIL halt_stuck[%0d] got valid=%0b halted=%0b exp 0/1", i, out_valid, halted); end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset got=%0b exp=0", halted); end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_illegal_and_reset();
        out_ready = 1'b1;
        present(6'h32, 32'h600);
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 25'h1000000) begin
            errors++; $display("FAIL illegal_ctrl got valid=%0b ctrl=%0h exp 1/1000000", out_valid, out_ctrl); end
        present(6'h04, 32'h604);
        tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== 25'h200004) begin
            errors++; $display("FAIL rst_mul_start got busy=%0b valid=%0b ctrl=%0h exp 1/0/200004", busy, out_valid, out_ctrl); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL rst_async_flags got busy=%0b valid=%0b halted=%0b exp 0", busy, out_valid, halted); end
        checks++; if (out_ctrl !== 25'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            errors++; $display("FAIL rst_async_payload got ctrl=%0h pc=%0h instr=%0h exp 0", out_ctrl, out_pc, out_instr); end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_resume got valid=%0b busy=%0b exp 0/0", out_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode_table();
        test_mul();
        test_backpressure();
        test_flush();
        test_halt();
        test_illegal_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
